// File: rtl/regfile_exec_sequencer.sv
`timescale 1ns/1ps
// Multi-cycle execute controller in front of a 4x8 register file:
// accept -> read operands -> ALU -> write back, with Z/C flags and a retire counter.
module regfile_exec_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2,
    localparam int unsigned IW    = 3 + 3*ADDR_W + DATA_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [IW-1:0]     instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] RA1,
    output logic [ADDR_W-1:0] RA2,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    output logic [ADDR_W-1:0] RA3,
    output logic [DATA_W-1:0] WD3,
    output logic              WE3,
    output logic              done,
    output logic              flag_z,
    output logic              flag_c,
    output logic [7:0]        instr_count
);

    localparam int unsigned OP_W    = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned RS2_LSB = DATA_W;
    localparam int unsigned RS1_LSB = DATA_W + ADDR_W;
    localparam int unsigned RD_LSB  = DATA_W + 2*ADDR_W;
    localparam int unsigned OP_LSB  = DATA_W + 3*ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_LDI = 3'd5,
        OP_MOV = 3'd6,
        OP_NOP = 3'd7
    } op_t;

    state_t state, state_d;

    op_t               op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic              carry_q, carry_d;

    logic [ADDR_W-1:0] ra1_d, ra2_d, ra3_d;
    logic [DATA_W-1:0] wd3_d;
    logic              we3_d;
    logic              done_d;
    logic              flag_z_d, flag_c_d;
    logic [CNT_W-1:0]  count_d;

    logic              accept;
    logic [DATA_W:0]   alu_sum;
    logic              alu_c;
    logic [DATA_W-1:0] alu_res;

    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: fixed four-cycle walk once an instruction is taken
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = DECODE;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ALU: 9-bit result, top bit is carry (ADD) or borrow (SUB)
    always_comb begin
        alu_sum = '0;
        case (op_q)
            OP_ADD:  alu_sum = {1'b0, opa_q} + {1'b0, opb_q};
            OP_SUB:  alu_sum = {1'b0, opa_q} - {1'b0, opb_q};
            OP_AND:  alu_sum = {1'b0, opa_q & opb_q};
            OP_OR:   alu_sum = {1'b0, opa_q | opb_q};
            OP_XOR:  alu_sum = {1'b0, opa_q ^ opb_q};
            OP_LDI:  alu_sum = {1'b0, imm_q};
            OP_MOV:  alu_sum = {1'b0, opa_q};
            default: alu_sum = '0;
        endcase
    end

    assign alu_c   = alu_sum[DATA_W];
    assign alu_res = alu_sum[DATA_W-1:0];

    // Output / datapath next values; everything holds unless its state touches it
    always_comb begin
        op_d     = op_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        carry_d  = carry_q;
        ra1_d    = RA1;
        ra2_d    = RA2;
        ra3_d    = RA3;
        wd3_d    = WD3;
        we3_d    = 1'b1;
        done_d   = 1'b0;
        flag_z_d = flag_z;
        flag_c_d = flag_c;
        count_d  = instr_count;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_d  = op_t'(instr[OP_LSB +: OP_W]);
                    rd_d  = instr[RD_LSB +: ADDR_W];
                    imm_d = instr[DATA_W-1:0];
                    ra1_d = instr[RS1_LSB +: ADDR_W];
                    ra2_d = instr[RS2_LSB +: ADDR_W];
                end
            end
            DECODE: begin
                opa_d = RD1;
                opb_d = RD2;
            end
            EXEC: begin
                ra3_d   = rd_q;
                wd3_d   = alu_res;
                carry_d = alu_c;
                we3_d   = (op_q == OP_NOP);
            end
            WRITE: begin
                done_d  = 1'b1;
                count_d = instr_count + CNT_W'(1);
                if (op_q != OP_NOP) begin
                    flag_z_d = (WD3 == '0);
                end
                case (op_q)
                    OP_ADD, OP_SUB:         flag_c_d = carry_q;
                    OP_AND, OP_OR, OP_XOR:  flag_c_d = 1'b0;
                    default:                flag_c_d = flag_c;
                endcase
            end
            default: ;
        endcase
    end

    // Registered outputs and operand latches; WE3 is async-set so reset cancels a pending write
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            op_q        <= OP_NOP;
            rd_q        <= '0;
            imm_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            carry_q     <= 1'b0;
            RA1         <= '0;
            RA2         <= '0;
            RA3         <= '0;
            WD3         <= '0;
            WE3         <= 1'b1;
            done        <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            instr_count <= '0;
        end else begin
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            carry_q     <= carry_d;
            RA1         <= ra1_d;
            RA2         <= ra2_d;
            RA3         <= ra3_d;
            WD3         <= wd3_d;
            WE3         <= we3_d;
            done        <= done_d;
            flag_z      <= flag_z_d;
            flag_c      <= flag_c_d;
            instr_count <= count_d;
        end
    end

endmodule

// File: tb/tb_regfile_exec_sequencer.sv
`timescale 1ns/1ps
// Bench for regfile_exec_sequencer: behavioural 4x8 register file, reference
// model feeding a retire-order scoreboard, directed stimulus.
module tb_regfile_exec_sequencer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned IW     = 17;

    logic              CLK = 1'b0;
    logic              reset;
    logic [IW-1:0]     instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] RA1, RA2, RA3;
    logic [DATA_W-1:0] RD1, RD2, WD3;
    logic              WE3, done, flag_z, flag_c;
    logic [7:0]        instr_count;

    regfile_exec_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .RA3(RA3), .WD3(WD3), .WE3(WE3), .done(done), .flag_z(flag_z),
        .flag_c(flag_c), .instr_count(instr_count)
    );

    always #5 CLK = ~CLK;

    // Register file: async read, write on edge while WE3 low, cleared by reset
    logic [DATA_W-1:0] rf [4];
    assign RD1 = rf[RA1];
    assign RD2 = rf[RA2];
    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (WE3 == 1'b0) begin
            rf[RA3] <= WD3;
        end
    end

    typedef struct packed {
        logic       wr;
        logic [1:0] rd;
        logic [7:0] wd;
        logic       z;
        logic       c;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    logic [7:0] m [4];
    logic       mz, mc;
    logic [7:0] mcnt;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: update architectural state and queue the expected retirement
    task automatic predict(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [7:0] imm);
        logic [7:0] a, b;
        logic [8:0] r;
        exp_t e;
        a = m[rs1];
        b = m[rs2];
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, imm};
            3'd6:    r = {1'b0, a};
            default: r = '0;
        endcase
        if (op != 3'd7) begin
            m[rd] = r[7:0];
            mz    = (r[7:0] == 8'd0);
            if (op <= 3'd1)      mc = r[8];
            else if (op <= 3'd4) mc = 1'b0;
        end
        mcnt  = mcnt + 8'd1;
        e.wr  = (op != 3'd7);
        e.rd  = rd;
        e.wd  = r[7:0];
        e.z   = mz;
        e.c   = mc;
        e.cnt = mcnt;
        q.push_back(e);
    endtask

    // Scoreboard: check every write strobe and every retirement against the queue head
    int   we_low = 0;
    exp_t got;
    always @(negedge CLK) begin
        if (reset) begin
            we_low = 0;
        end else begin
            if (WE3 === 1'b0) begin
                we_low++;
                chk("write_has_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    chk("write_allowed", 32'd1, 32'(q[0].wr));
                    chk("RA3", 32'(RA3), 32'(q[0].rd));
                    chk("WD3", 32'(WD3), 32'(q[0].wd));
                end
            end
            if (done === 1'b1) begin
                chk("done_has_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    got = q.pop_front();
                    chk("we3_low_cycles", 32'(we_low), got.wr ? 32'd1 : 32'd0);
                    chk("flag_z", 32'(flag_z), 32'(got.z));
                    chk("flag_c", 32'(flag_c), 32'(got.c));
                    chk("instr_count", 32'(instr_count), 32'(got.cnt));
                end
                we_low = 0;
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [7:0] imm);
        instr       = {op, rd, rs1, rs2, imm};
        instr_valid = 1'b1;
    endtask

    // One isolated instruction; junk is offered while busy to show it is ignored
    task automatic run_one(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [7:0] imm);
        int lat;
        @(negedge CLK);
        chk("ready_idle", 32'(instr_ready), 32'd1);
        drive(op, rd, rs1, rs2, imm);
        predict(op, rd, rs1, rs2, imm);
        @(posedge CLK);
        #1;
        instr = IW'($urandom);
        lat   = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            if (i == 3) instr_valid = 1'b0;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), 32'd4);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        instr_valid = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) m[i] = 8'd0;
        mz   = 1'b0;
        mc   = 1'b0;
        mcnt = 8'd0;
        #1;
        chk("rst_WE3", 32'(WE3), 32'd1);
        chk("rst_RA1", 32'(RA1), 32'd0);
        chk("rst_RA2", 32'(RA2), 32'd0);
        chk("rst_RA3", 32'(RA3), 32'd0);
        chk("rst_WD3", 32'(WD3), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flag_z", 32'(flag_z), 32'd0);
        chk("rst_flag_c", 32'(flag_c), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
    endtask

    // Accept an instruction and stop at the negedge of the given post-accept cycle
    task automatic start_and_hold(input logic [1:0] rd, input logic [7:0] imm, input int cyc);
        @(negedge CLK);
        drive(3'd5, rd, 2'd0, 2'd0, imm);
        predict(3'd5, rd, 2'd0, 2'd0, imm);
        @(posedge CLK);
        #1;
        instr_valid = 1'b0;
        repeat (cyc) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] pat;
        int dones;
        reset       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        #2;
        do_reset();

        // LDI/LDI/ADD with carry out
        run_one(3'd5, 2'd1, 2'd0, 2'd0, 8'h03);
        run_one(3'd5, 2'd2, 2'd0, 2'd0, 8'hFE);
        run_one(3'd0, 2'd3, 2'd1, 2'd2, 8'h00);
        chk("rf_r3_add", 32'(rf[3]), 32'h01);

        // SUB to zero, then borrow
        run_one(3'd1, 2'd0, 2'd1, 2'd1, 8'h00);
        chk("rf_r0_sub0", 32'(rf[0]), 32'h00);
        run_one(3'd1, 2'd0, 2'd1, 2'd2, 8'h00);
        chk("rf_r0_sub", 32'(rf[0]), 32'h05);

        // Logic ops, MOV (C preserved), LDI zero
        run_one(3'd2, 2'd0, 2'd2, 2'd1, 8'h00);
        run_one(3'd0, 2'd3, 2'd2, 2'd2, 8'h00);
        run_one(3'd3, 2'd3, 2'd1, 2'd2, 8'h00);
        run_one(3'd1, 2'd0, 2'd1, 2'd2, 8'h00);
        run_one(3'd6, 2'd0, 2'd2, 2'd0, 8'h00);
        run_one(3'd4, 2'd3, 2'd2, 2'd2, 8'h00);
        run_one(3'd5, 2'd0, 2'd0, 2'd0, 8'h00);
        chk("rf_r0_mov_ldi", 32'(rf[0]), 32'h00);
        run_one(3'd5, 2'd1, 2'd0, 2'd0, 8'h03);

        // Back-to-back ADD r1,r1,r1 with valid held high
        @(negedge CLK);
        drive(3'd0, 2'd1, 2'd1, 2'd1, 8'h00);
        predict(3'd0, 2'd1, 2'd1, 2'd1, 8'h00);
        predict(3'd0, 2'd1, 2'd1, 2'd1, 8'h00);
        pat = 9'b1_0001_0001;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) @(negedge CLK);
            chk("b2b_ready", 32'(instr_ready), 32'(pat[i]));
            chk("b2b_done", 32'(done), 32'(i == 4 || i == 8));
            if (i == 4) chk("b2b_r1_first", 32'(rf[1]), 32'h06);
            if (i == 8) instr_valid = 1'b0;
        end
        chk("b2b_r1_second", 32'(rf[1]), 32'h0C);

        // Reset during EXEC aborts the LDI
        run_one(3'd5, 2'd2, 2'd0, 2'd0, 8'hAA);
        chk("rf_r2_aa", 32'(rf[2]), 32'hAA);
        start_and_hold(2'd2, 8'h55, 2);
        do_reset();
        chk("rf_r2_cleared", 32'(rf[2]), 32'h00);
        run_one(3'd5, 2'd2, 2'd0, 2'd0, 8'h11);
        chk("rf_r2_after_rst", 32'(rf[2]), 32'h11);

        // Reset while the write strobe is active
        start_and_hold(2'd3, 8'h77, 3);
        chk("we3_in_write", 32'(WE3), 32'd0);
        do_reset();
        chk("rf_r3_no_write", 32'(rf[3]), 32'h00);

        // Get flags/count to non-trivial values, then 256 NOPs back-to-back
        run_one(3'd5, 2'd1, 2'd0, 2'd0, 8'hF0);
        run_one(3'd0, 2'd2, 2'd1, 2'd1, 8'h00);
        run_one(3'd1, 2'd3, 2'd0, 2'd1, 8'h00);
        @(negedge CLK);
        drive(3'd7, 2'd2, 2'd1, 2'd3, 8'h5A);
        for (int i = 0; i < 256; i++) predict(3'd7, 2'd2, 2'd1, 2'd3, 8'h5A);
        dones = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge CLK);
            if (done === 1'b1) dones++;
            if (dones == 256) break;
        end
        instr_valid = 1'b0;
        chk("nop_dones", 32'(dones), 32'd256);
        chk("nop_count", 32'(instr_count), 32'd3);
        chk("rf_r2_nop", 32'(rf[2]), 32'hE0);
        repeat (3) @(negedge CLK);
        chk("queue_empty", 32'(q.size()), 32'd0);
        chk("final_done", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
